mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding-access bridge between the CPU decoder and an
// external request/acknowledge bus. Reads return registered data with a
// one-cycle mem_ready pulse; writes complete silently. A wait counter aborts
// accesses whose acknowledge never arrives and raises a sticky error flag.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no access in flight; accepts ram_write (priority) or ram_read
// RD_WAIT   | read on the bus, waiting for bus_ack or timeout
// WR_WAIT   | write on the bus, waiting for bus_ack or timeout
// RD_DONE   | rdata valid, mem_ready pulsed; always back to IDLE next cycle

module mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        mem_busy,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_req,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;
    localparam logic [1:0] S_RD_DONE = 2'd3;

    // The counter reaches TIMEOUT on the edge that ends the wait cycle in
    // which it holds TIMEOUT-1, so that is the value the abort decision uses.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;

    // Next-state logic: request acceptance, ack/timeout resolution.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            S_IDLE: begin
                if (ram_write) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_WR_WAIT;
                end else if (ram_read) begin
                    addr_d  = addr;
                    we_d    = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // An ack on the final allowed cycle still wins over the abort.
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    state_d = S_RD_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 16'hFFFF;
                    state_d = S_RD_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WR_WAIT: begin
                if (bus_ack) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RD_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 16'd0;
            err_q   <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign mem_busy  = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
    assign bus_req   = mem_busy;
    assign mem_ready = (state_q == S_RD_DONE);
    assign mem_err   = err_q;
    assign rdata     = rdata_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;

endmodule
